uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of byte requesters sharing one txuart (range 2..8).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 15, giving the maximum cycles to wait for tx_busy to rise after a strobe.
REQ-003 The block SHALL have port clk_24, input, 1 bit: the single 24 MHz clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: requester i holds bit i high while it has a byte to send.
REQ-006 The block SHALL have port req_data, input, 8*NREQ bits: byte i occupies bits [8i+7:8i] and is held stable while req_valid[i] is high.
REQ-007 The block SHALL have port req_ready, output, NREQ bits: a one-cycle pulse on bit i that completes requester i's transfer.
REQ-008 The block SHALL have port tx_stb, output, 1 bit: the send strobe to txuart.
REQ-009 The block SHALL have port tx_data, output, 8 bits: the byte presented to txuart.
REQ-010 The block SHALL have port tx_busy, input, 1 bit: txuart busy indication.
REQ-011 The block SHALL have port grant, output, 3 bits: the index of the current or last winner.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: a one-cycle pulse when a strobe is not acknowledged.

Function
REQ-013 The block SHALL implement the FSM states IDLE, START, WAIT_BUSY and WAIT_IDLE.
REQ-014 In IDLE with any req_valid high, the block SHALL select a winner round-robin, starting the search at pointer rr_ptr and wrapping NREQ-1 -> 0.
REQ-015 On that edge the block SHALL latch tx_data from the winner, set grant to the winner, set rr_ptr to (winner+1) mod NREQ, and go to START.
REQ-016 In START, tx_stb and req_ready[winner] SHALL both be high for exactly one cycle, after which the state is WAIT_BUSY.
REQ-017 Latency from req_valid high in IDLE to tx_stb high SHALL be exactly 1 cycle.
REQ-018 In WAIT_BUSY, tx_busy=1 SHALL move the FSM to WAIT_IDLE.
REQ-019 In WAIT_BUSY, BUSY_TIMEOUT cycles without tx_busy SHALL pulse timeout_err for one cycle and return the FSM to IDLE; the byte is dropped and not retried.
REQ-020 In WAIT_IDLE, tx_busy=0 SHALL return the FSM to IDLE; no new byte SHALL be issued while tx_busy=1.
REQ-021 The minimum spacing between consecutive tx_stb pulses SHALL be 4 cycles.
REQ-022 req_valid SHALL be sampled only in IDLE; changes in other states SHALL be ignored.
REQ-023 A requester dropping req_valid before req_ready SHALL lose arbitration with no side effects.
REQ-024 When several requests are valid simultaneously, the block SHALL grant exactly one, and every continuously valid requester SHALL be granted within NREQ transfers.
REQ-025 tx_data and grant SHALL hold their values until the next accept.
REQ-026 The timeout counter SHALL be 4 bits, SHALL clear on entry to WAIT_BUSY, and SHALL saturate without wrapping.

Reset
REQ-027 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set rr_ptr=0, grant=0, tx_data=0, tx_stb=0, req_ready=0, timeout_err=0 and timeout counter=0.
REQ-028 Reset in any state, including mid-START, SHALL cancel the transfer with no strobe or ready pulse after the reset edge.
REQ-029 After reset, arbitration SHALL resume on the first cycle with rst_n=1.

Structure
REQ-030 The FSM state encoding and the default parameter values SHALL be placed in a shared package, uart_pkg, alongside the txuart setup-word constant.
REQ-031 Round-robin winner selection SHALL be a separate combinational sub-module, rr_pick, with inputs req and ptr and outputs any and idx.
REQ-032 No other sub-module SHALL be instantiated.

Verification
REQ-033 The bench SHALL cover: single request (req_valid=001, data 0x41, tx_busy high 2 cycles after the strobe for 10 cycles) -> tx_stb 1 cycle after valid, tx_data=0x41, req_ready=001 for one pulse, grant=0.
REQ-034 The bench SHALL cover: all three requesters continuously valid (0x61, 0x62, 0x63) -> tx_data order 0x61, 0x62, 0x63, 0x61, and no strobe while tx_busy=1.
REQ-035 The bench SHALL cover: tx_busy held 0 after the strobe -> timeout_err pulses exactly 15 cycles after leaving START, then the FSM returns to IDLE and serves the next requester.
REQ-036 The bench SHALL cover: rst_n=0 during the START cycle -> no req_ready pulse and no further tx_stb after reset, and rr_ptr=0 afterwards.
REQ-037 The bench SHALL cover: req_valid[1] pulsed high only while the FSM is in WAIT_IDLE -> no grant to requester 1.
REQ-038 The bench SHALL cover: a requester whose bit is raised back-to-back after its req_ready pulse, against competing requesters -> it is not granted twice in a row.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the txuart byte arbiter.
package uart_pkg;
  localparam int NREQ_DEF         = 3;
  localparam int BUSY_TIMEOUT_DEF = 15;
  localparam int PTR_W            = 3;

  // txuart setup word: 8N1, clocks-per-baud for 115200 at 24 MHz
  localparam logic [30:0] TXUART_SETUP = 31'd208;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted req at or after ptr, wrapping N-1 -> 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = NREQ_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);
  logic [PTR_W:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int off = N - 1; off >= 0; off--) begin
      w_cand = {1'b0, ptr} + (PTR_W + 1)'(off);
      if (w_cand >= (PTR_W + 1)'(N)) w_cand = w_cand - (PTR_W + 1)'(N);
      for (int i = 0; i < N; i++) begin
        if (w_cand == (PTR_W + 1)'(i) && req[i]) begin
          any = 1'b1;
          idx = PTR_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one txuart between NREQ byte requesters with round-robin arbitration
// and a bounded wait for the UART to acknowledge each strobe.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic              clk_24,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_stb,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [2:0]        grant,
  output logic              timeout_err
);
  localparam logic [3:0] TO_LAST = 4'(BUSY_TIMEOUT - 1);

  arb_state_t       r_state, w_next;
  logic [PTR_W-1:0] r_ptr, r_grant, w_idx;
  logic [7:0]       r_data, w_sel;
  logic [3:0]       r_cnt;
  logic             r_to, w_any;

  rr_pick #(.N(NREQ)) u_pick (
    .req (req_valid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_idx == PTR_W'(i)) w_sel = req_data[8*i +: 8];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_any) w_next = START;
      START:     w_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) w_next = WAIT_IDLE;
                 else if (r_cnt == TO_LAST) w_next = IDLE;
      WAIT_IDLE: if (!tx_busy) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_24) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_to    <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_grant <= w_idx;
          r_data  <= w_sel;
          r_ptr   <= (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end
        START: r_cnt <= '0;
        WAIT_BUSY: if (!tx_busy) begin
          if (r_cnt == TO_LAST) r_to <= 1'b1;
          else if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Gated by rst_n so a reset landing in START suppresses the strobe itself.
  assign tx_stb = (r_state == START) && rst_n;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = tx_stb && (r_grant == PTR_W'(i));
  end

  assign tx_data     = r_data;
  assign grant       = r_grant;
  assign timeout_err = r_to;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected strobes/hold values, a negedge monitor checks them.
module tb_uart_tx_arbiter;
  localparam int NREQ = 3;

  typedef struct {
    logic [7:0] data;
    logic [2:0] grant;
    int         cyc;
    bit         to;
  } exp_t;

  typedef struct {
    bit         full;
    logic [7:0] data;
    logic [2:0] grant;
  } hold_t;

  logic              clk_24 = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_stb;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [2:0]        grant;
  logic              timeout_err;

  exp_t  exp_q[$];
  hold_t hold_q[$];
  int    cyc = 0, total = 0, bad = 0, pend_to = -1, last_stb = -1;
  bit    done = 0, mute = 0, busy_active = 0;
  int    busy_dly = 2, busy_len = 10;

  uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(15)) dut (
    .clk_24(clk_24), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_stb(tx_stb), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk_24 = ~clk_24;

  // txuart model: busy rises busy_dly edges after a strobe, for busy_len cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk_24);
      if (tx_stb === 1'b1 && !mute) begin
        busy_active = 1;
        repeat (busy_dly) @(posedge clk_24);
        #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk_24);
        #1 tx_busy = 1'b0;
        busy_active = 0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk_24) begin
    exp_t  e;
    hold_t h;
    logic [NREQ-1:0] oh;
    cyc++;
    if (hold_q.size() > 0) begin
      h = hold_q.pop_front();
      total++;
      if (tx_data !== h.data || grant !== h.grant ||
          (h.full && (tx_stb !== 1'b0 || req_ready !== '0 || timeout_err !== 1'b0))) begin
        bad++;
        $display("FAIL hold@%0d: got data=%h grant=%0d stb=%b rdy=%b to=%b, want data=%h grant=%0d%s",
                 cyc, tx_data, grant, tx_stb, req_ready, timeout_err, h.data, h.grant,
                 h.full ? " stb=0 rdy=0 to=0" : "");
      end
    end
    if (tx_stb !== 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_stb@%0d: got stb=%b data=%h grant=%0d, want no strobe",
                 cyc, tx_stb, tx_data, grant);
      end else begin
        e = exp_q.pop_front();
        oh = '0;
        oh[e.grant] = 1'b1;
        if (tx_data !== e.data || grant !== e.grant || req_ready !== oh) begin
          bad++;
          $display("FAIL stb@%0d: got data=%h grant=%0d rdy=%b, want data=%h grant=%0d rdy=%b",
                   cyc, tx_data, grant, req_ready, e.data, e.grant, oh);
        end
        if (e.cyc >= 0) begin
          total++;
          if (cyc != e.cyc) begin
            bad++;
            $display("FAIL latency: got stb at cycle %0d, want %0d", cyc, e.cyc);
          end
        end
        if (e.to) pend_to = cyc + 16;
      end
      total++;
      if (tx_busy !== 1'b0 || (last_stb >= 0 && cyc - last_stb < 4)) begin
        bad++;
        $display("FAIL spacing@%0d: got busy=%b gap=%0d, want busy=0 gap>=4",
                 cyc, tx_busy, cyc - last_stb);
      end
      last_stb = cyc;
    end else if (req_ready !== '0) begin
      total++;
      bad++;
      $display("FAIL ready_no_stb@%0d: got rdy=%b, want 0", cyc, req_ready);
    end
    if (timeout_err !== 1'b0 || cyc == pend_to) begin
      total++;
      if (timeout_err !== (cyc == pend_to)) begin
        bad++;
        $display("FAIL timeout@%0d: got timeout_err=%b, want %b", cyc, timeout_err, cyc == pend_to);
      end
    end
    if (done || cyc > 20000) begin
      total++;
      if (exp_q.size() != 0 || hold_q.size() != 0 || !done) begin
        bad++;
        $display("FAIL leftover: got %0d strobes/%0d holds pending done=%b, want 0/0 done=1",
                 exp_q.size(), hold_q.size(), done);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk_24);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    hold_q.push_back('{1'b1, 8'h00, 3'd0});
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_any_ready(output int who);
    who = -1;
    for (int k = 0; k < 200 && who < 0; k++) begin
      @(negedge clk_24);
      for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) who = i;
    end
    if (who < 0) begin
      $display("FAIL wait_ready: got no req_ready pulse in 200 cycles, want one");
      $fatal(1);
    end
  endtask

  task automatic wait_quiet();
    for (int k = 0; k < 200 && (busy_active || tx_busy); k++) @(posedge clk_24);
    repeat (6) @(posedge clk_24);
    #1;
  endtask

  initial begin
    int who;
    bit first0;
    // single request, valid raised on the first cycle out of reset
    do_reset();
    req_data  = {8'h00, 8'h00, 8'h41};
    req_valid = 3'b001;
    exp_q.push_back('{8'h41, 3'd0, cyc + 2, 1'b0});
    wait_any_ready(who);
    tick();
    req_valid = '0;
    wait_quiet();
    hold_q.push_back('{1'b0, 8'h41, 3'd0});
    tick();

    // three continuous requesters, round-robin order
    do_reset();
    busy_len  = 3;
    req_data  = {8'h63, 8'h62, 8'h61};
    req_valid = 3'b111;
    exp_q.push_back('{8'h61, 3'd0, -1, 1'b0});
    exp_q.push_back('{8'h62, 3'd1, -1, 1'b0});
    exp_q.push_back('{8'h63, 3'd2, -1, 1'b0});
    exp_q.push_back('{8'h61, 3'd0, -1, 1'b0});
    for (int n = 0; n < 4; n++) begin
      wait_any_ready(who);
      tick();
    end
    req_valid = '0;
    wait_quiet();

    // no busy acknowledge: timeout, byte dropped, next requester served
    do_reset();
    mute      = 1;
    req_data  = {8'h00, 8'h20, 8'h10};
    req_valid = 3'b011;
    exp_q.push_back('{8'h10, 3'd0, -1, 1'b1});
    exp_q.push_back('{8'h20, 3'd1, -1, 1'b0});
    wait_any_ready(who);
    tick();
    req_valid[0] = 1'b0;
    mute = 0;
    wait_any_ready(who);
    tick();
    req_valid = '0;
    wait_quiet();

    // reset during START: no strobe, pointer back to 0
    do_reset();
    req_data  = {8'h00, 8'h00, 8'h55};
    req_valid = 3'b001;
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    hold_q.push_back('{1'b1, 8'h00, 3'd0});
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    req_data  = {8'h00, 8'hB0, 8'hA0};
    req_valid = 3'b011;
    exp_q.push_back('{8'hA0, 3'd0, -1, 1'b0});
    exp_q.push_back('{8'hB0, 3'd1, -1, 1'b0});
    for (int n = 0; n < 2; n++) begin
      wait_any_ready(who);
      tick();
      req_valid[who] = 1'b0;
    end
    wait_quiet();

    // requester 1 pulses only while the UART is busy: ignored
    busy_len  = 6;
    req_data  = {8'h00, 8'h31, 8'h30};
    req_valid = 3'b001;
    exp_q.push_back('{8'h30, 3'd0, -1, 1'b0});
    wait_any_ready(who);
    tick();
    req_valid = '0;
    for (int k = 0; k < 50 && tx_busy !== 1'b1; k++) @(negedge clk_24);
    tick();
    req_valid[1] = 1'b1;
    repeat (2) tick();
    req_valid[1] = 1'b0;
    wait_quiet();
    hold_q.push_back('{1'b0, 8'h30, 3'd0});
    tick();

    // requester 0 re-raises right after its ready: not granted twice in a row
    do_reset();
    busy_len  = 3;
    req_data  = {8'h72, 8'h71, 8'h70};
    req_valid = 3'b011;
    exp_q.push_back('{8'h70, 3'd0, -1, 1'b0});
    exp_q.push_back('{8'h71, 3'd1, -1, 1'b0});
    exp_q.push_back('{8'h72, 3'd2, -1, 1'b0});
    exp_q.push_back('{8'h70, 3'd0, -1, 1'b0});
    first0 = 1;
    for (int n = 0; n < 4; n++) begin
      wait_any_ready(who);
      tick();
      req_valid[who] = 1'b0;
      if (who == 0 && first0) begin
        first0 = 0;
        tick();
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
      end
    end
    wait_quiet();
    done = 1;
  end
endmodule
